// File: rtl/stream_demux_if.sv
// Handshake bundle for stream_demux: one input stream, NCH one-word output slots.
// The in_bcast signal exists only when STREAM_DEMUX_BROADCAST_EN is defined.
interface stream_demux_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 8,
  parameter int SEL_W = $clog2(NCH)
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
`ifdef STREAM_DEMUX_BROADCAST_EN
  logic                   in_bcast;
`endif
  logic [NCH-1:0]         out_valid;
  logic [NCH-1:0]         out_ready;
  logic [NCH*WIDTH-1:0]   out_data;
  logic                   err;
  logic [7:0]             drop_cnt;

`ifdef STREAM_DEMUX_BROADCAST_EN
  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, err, drop_cnt
  );
  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, err, drop_cnt
  );
`else
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, err, drop_cnt
  );
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, err, drop_cnt
  );
`endif
endinterface

// File: rtl/stream_demux.sv
// Routes one input stream into NCH independent one-entry output slots by in_sel.
// Define STREAM_DEMUX_BROADCAST_EN to add in_bcast (load all slots at once).
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int NCH   = 8,
  parameter int SEL_W = $clog2(NCH)
) (
  input logic           clk,
  input logic           rst,
  stream_demux_if.slave bus
);

  logic [NCH-1:0]       valid_q, valid_d;
  logic [NCH*WIDTH-1:0] data_q, data_d;
  logic                 err_q, err_d;
  logic [7:0]           drop_q, drop_d;

  logic [NCH-1:0]       drain;
  logic [NCH-1:0]       slot_free;
  logic                 tgt_free;
  logic                 sel_ok;
  logic                 in_ready;
  logic                 accept;
  logic [NCH*WIDTH-1:0] out_data;

  // With a power-of-two channel count every select value names a real slot.
  if (NCH == (1 << SEL_W)) begin : g_pow2
    assign sel_ok = 1'b1;
  end else begin : g_npow2
    assign sel_ok = (int'(bus.in_sel) < NCH);
  end

  always_comb begin
    drain     = valid_q & bus.out_ready;
    slot_free = ~valid_q | bus.out_ready;
    tgt_free  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (bus.in_sel == SEL_W'(k)) tgt_free = slot_free[k];
    end
    if (rst) begin
      in_ready = 1'b0;
    end else begin
`ifdef STREAM_DEMUX_BROADCAST_EN
      if (bus.in_bcast) in_ready = &slot_free;
      else              in_ready = !sel_ok || tgt_free;
`else
      in_ready = !sel_ok || tgt_free;
`endif
    end
  end

  always_comb begin
    valid_d = valid_q & ~drain;
    data_d  = data_q;
    err_d   = 1'b0;
    drop_d  = drop_q;
    accept  = bus.in_valid & in_ready;
    if (accept) begin
`ifdef STREAM_DEMUX_BROADCAST_EN
      if (bus.in_bcast) begin
        valid_d = '1;
        data_d  = {NCH{bus.in_data}};
      end else
`endif
      if (sel_ok) begin
        for (int k = 0; k < NCH; k++) begin
          if (bus.in_sel == SEL_W'(k)) begin
            valid_d[k]               = 1'b1;
            data_d[k*WIDTH +: WIDTH] = bus.in_data;
          end
        end
      end else begin
        err_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      drop_q  <= 8'd0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  // Stored words are kept untouched while empty; only the visible output is masked.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (valid_q[k]) out_data[k*WIDTH +: WIDTH] = data_q[k*WIDTH +: WIDTH];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = out_data;
  assign bus.err       = err_q;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: an 8-channel and a 6-channel instance run in lockstep
// against a slot-level reference model; directed scenarios then random traffic.
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_demux_if #(.WIDTH(8), .NCH(8)) bus8();
  stream_demux_if #(.WIDTH(8), .NCH(6)) bus6();

  stream_demux #(.WIDTH(8), .NCH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  stream_demux #(.WIDTH(8), .NCH(6)) u_dut6 (.clk(clk), .rst(rst), .bus(bus6));

  int checks = 0;
  int errors = 0;

  // stimulus per unit (0: NCH=8, 1: NCH=6)
  bit         vv[2];
  logic [7:0] dd[2];
  logic [2:0] ss[2];
  logic [7:0] orr[2];
  bit         bc;

  // reference model: one slot per channel
  bit         mv[2][8];
  logic [7:0] md[2][8];
  bit         merr[2];
  int         mdrop[2];
  int         nch[2] = '{8, 6};

  logic       last_rdy[2];
  logic [7:0] got2[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready(int u);
    if (rst) return 1'b0;
    if (u == 0 && bc) begin
      for (int k = 0; k < 8; k++) if (mv[0][k] && !orr[0][k]) return 1'b0;
      return 1'b1;
    end
    if (int'(ss[u]) >= nch[u]) return 1'b1;
    return !mv[u][ss[u]] || orr[u][ss[u]];
  endfunction

  task automatic model_step(int u, bit rdy);
    merr[u] = 1'b0;
    if (rst) begin
      for (int k = 0; k < 8; k++) begin mv[u][k] = 1'b0; md[u][k] = 8'h00; end
      mdrop[u] = 0;
      return;
    end
    for (int k = 0; k < nch[u]; k++) if (mv[u][k] && orr[u][k]) mv[u][k] = 1'b0;
    if (vv[u] && rdy) begin
      if (u == 0 && bc) begin
        for (int k = 0; k < 8; k++) begin mv[u][k] = 1'b1; md[u][k] = dd[u]; end
      end else if (int'(ss[u]) < nch[u]) begin
        mv[u][ss[u]] = 1'b1;
        md[u][ss[u]] = dd[u];
      end else begin
        merr[u] = 1'b1;
        if (mdrop[u] < 255) mdrop[u]++;
      end
    end
  endtask

  function automatic logic [63:0] dut_ov(int u);
    return (u == 0) ? 64'(bus8.out_valid) : 64'(bus6.out_valid);
  endfunction
  function automatic logic [63:0] dut_od(int u);
    return (u == 0) ? 64'(bus8.out_data) : 64'(bus6.out_data);
  endfunction
  function automatic logic [63:0] dut_err(int u);
    return (u == 0) ? 64'(bus8.err) : 64'(bus6.err);
  endfunction
  function automatic logic [63:0] dut_drop(int u);
    return (u == 0) ? 64'(bus8.drop_cnt) : 64'(bus6.drop_cnt);
  endfunction

  // Called just after a rising edge: apply inputs, check ready mid-cycle, clock, check outputs.
  task automatic step();
    bit          er[2];
    logic [63:0] ev, eod;
    bus8.in_valid  = vv[0];
    bus8.in_data   = dd[0];
    bus8.in_sel    = ss[0];
    bus8.out_ready = orr[0];
    bus6.in_valid  = vv[1];
    bus6.in_data   = dd[1];
    bus6.in_sel    = ss[1];
    bus6.out_ready = orr[1][5:0];
`ifdef STREAM_DEMUX_BROADCAST_EN
    bus8.in_bcast  = bc;
    bus6.in_bcast  = 1'b0;
`endif
    #3;
    last_rdy[0] = bus8.in_ready;
    last_rdy[1] = bus6.in_ready;
    if (!rst && bus8.out_valid[2] && bus8.out_ready[2]) got2.push_back(bus8.out_data[23:16]);
    for (int u = 0; u < 2; u++) begin
      er[u] = model_ready(u);
      chk($sformatf("in_ready u%0d", u), 64'(last_rdy[u]), 64'(er[u]));
    end
    for (int u = 0; u < 2; u++) model_step(u, er[u]);
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      ev  = '0;
      eod = '0;
      for (int k = 0; k < nch[u]; k++) begin
        ev[k] = mv[u][k];
        if (mv[u][k]) eod[k*8 +: 8] = md[u][k];
      end
      chk($sformatf("out_valid u%0d", u), dut_ov(u), ev);
      chk($sformatf("out_data u%0d", u), dut_od(u), eod);
      chk($sformatf("err u%0d", u), dut_err(u), 64'(merr[u]));
      chk($sformatf("drop_cnt u%0d", u), dut_drop(u), 64'(mdrop[u]));
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      vv[u] = 1'b0; dd[u] = 8'h00; ss[u] = 3'd0; orr[u] = 8'hFF; merr[u] = 1'b0; mdrop[u] = 0;
      for (int k = 0; k < 8; k++) begin mv[u][k] = 1'b0; md[u][k] = 8'h00; end
    end
    bc = 1'b0;
    @(posedge clk);
    #1;

    // reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset out_valid", 64'(bus8.out_valid), 64'h0);
    chk("reset drop_cnt", 64'(bus6.drop_cnt), 64'h0);

    // single word to slot 3
    vv[0] = 1'b1; dd[0] = 8'hA5; ss[0] = 3'd3;
    step();
    vv[0] = 1'b0;
    chk("single out_valid", 64'(bus8.out_valid), 64'h08);
    chk("single out_data", 64'(bus8.out_data), 64'h0000_0000_A500_0000);
    step();

    // stalled channel 2 does not block channel 5, no loss on release
    orr[0] = 8'hFB;
    vv[0] = 1'b1; dd[0] = 8'h11; ss[0] = 3'd2;
    step();
    dd[0] = 8'h22;
    step();
    chk("stall in_ready", 64'(last_rdy[0]), 64'h0);
    dd[0] = 8'h33; ss[0] = 3'd5;
    step();
    chk("other ch in_ready", 64'(last_rdy[0]), 64'h1);
    orr[0] = 8'hFF; dd[0] = 8'h22; ss[0] = 3'd2;
    step();
    chk("refill in_ready", 64'(last_rdy[0]), 64'h1);
    vv[0] = 1'b0;
    step();
    step();
    chk("delivered count", 64'(got2.size()), 64'd2);
    if (got2.size() == 2) begin
      chk("delivered first", 64'(got2[0]), 64'h11);
      chk("delivered second", 64'(got2[1]), 64'h22);
    end

    // drain and load same slot in one cycle
    vv[0] = 1'b1; dd[0] = 8'h40; ss[0] = 3'd4;
    step();
    dd[0] = 8'h7E;
    step();
    vv[0] = 1'b0;
    chk("no bubble valid", 64'(bus8.out_valid[4]), 64'h1);
    chk("no bubble data", 64'(bus8.out_data[39:32]), 64'h7E);
    step();

    // out-of-range selects on the 6-channel unit
    vv[1] = 1'b1; ss[1] = 3'd7;
    for (int i = 0; i < 3; i++) begin
      dd[1] = 8'($urandom);
      step();
      chk("oor in_ready", 64'(last_rdy[1]), 64'h1);
      chk("oor err pulse", 64'(bus6.err), 64'h1);
    end
    chk("oor drop3", 64'(bus6.drop_cnt), 64'd3);
    chk("oor no valid", 64'(bus6.out_valid), 64'h0);
    for (int i = 0; i < 300; i++) begin
      dd[1] = 8'($urandom);
      ss[1] = 3'($urandom_range(6, 7));
      step();
    end
    vv[1] = 1'b0;
    chk("drop saturate", 64'(bus6.drop_cnt), 64'd255);
    step();
    chk("err cleared", 64'(bus6.err), 64'h0);

    // reset while slots are full and stalled
    orr[0] = 8'h00;
    vv[0] = 1'b1;
    dd[0] = 8'hC0; ss[0] = 3'd0; step();
    dd[0] = 8'hC1; ss[0] = 3'd1; step();
    dd[0] = 8'hC6; ss[0] = 3'd6; step();
    chk("full before rst", 64'(bus8.out_valid), 64'h43);
    orr[0] = 8'hFF; dd[0] = 8'hEE; ss[0] = 3'd7;
    rst = 1'b1;
    step();
    chk("rst in_ready", 64'(last_rdy[0]), 64'h0);
    rst = 1'b0;
    vv[0] = 1'b0;
    chk("rst out_valid", 64'(bus8.out_valid), 64'h0);
    chk("rst out_data", 64'(bus8.out_data), 64'h0);
    chk("rst drop_cnt", 64'(bus6.drop_cnt), 64'h0);
    step();

`ifdef STREAM_DEMUX_BROADCAST_EN
    orr[0] = 8'hFF;
    vv[0] = 1'b1; bc = 1'b1; dd[0] = 8'h5A; ss[0] = 3'($urandom);
    step();
    chk("bcast valid", 64'(bus8.out_valid), 64'hFF);
    chk("bcast data", 64'(bus8.out_data), {8{8'h5A}});
    chk("bcast no err", 64'(bus8.err), 64'h0);
    bc = 1'b0; orr[0] = 8'hF7; dd[0] = 8'h31; ss[0] = 3'd3;
    step();
    bc = 1'b1; dd[0] = 8'h77;
    step();
    chk("bcast blocked", 64'(last_rdy[0]), 64'h0);
    bc = 1'b0; vv[0] = 1'b0; orr[0] = 8'hFF;
    step();
    step();
`endif

    // random traffic on both units
    for (int i = 0; i < 400; i++) begin
      for (int u = 0; u < 2; u++) begin
        vv[u]  = 1'($urandom_range(0, 3) != 0);
        dd[u]  = 8'($urandom);
        ss[u]  = 3'($urandom);
        orr[u] = 8'($urandom);
      end
`ifdef STREAM_DEMUX_BROADCAST_EN
      bc = ($urandom_range(0, 7) == 0);
`endif
      step();
    end
    bc = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 Parameter WIDTH, default 8: data width of the input and of each output channel.
REQ-002 Parameter NCH, default 8: number of output channels; legal range 2..64.
REQ-003 Parameter SEL_W, default $clog2(NCH): select width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  upstream offers a word.
REQ-007 in_ready  output  1  block accepts the offered word this cycle.
REQ-008 in_data  input  WIDTH  word to route.
REQ-009 in_sel  input  SEL_W  destination channel index.
REQ-010 out_valid  output  NCH  bit k: channel k holds a word.
REQ-011 out_ready  input  NCH  bit k: downstream k takes the word this cycle.
REQ-012 out_data  output  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-013 err  output  1  one-cycle pulse: an accepted word had an out-of-range select.
REQ-014 drop_cnt  output  8  saturating count of out-of-range words dropped.

Function
REQ-015 Each channel SHALL have a one-entry holding register with a valid flag.
REQ-016 Input transfer SHALL occur when in_valid and in_ready are both 1 in the same cycle.
REQ-017 Output transfer on channel k SHALL occur when out_valid[k] and out_ready[k] are both 1 in the same cycle.
REQ-018 in_ready SHALL be combinational and equal to 1 when the target slot is empty, is draining this cycle, or in_sel >= NCH; otherwise it SHALL be 0.
REQ-019 An input transfer to a valid channel k SHALL load in_data into slot k; out_valid[k] SHALL be 1 in the next cycle (latency 1).
REQ-020 Simultaneous drain and load of the same slot SHALL keep out_valid[k]=1 with the new data; there SHALL be no bubble.
REQ-021 A drain without a load SHALL clear out_valid[k] in the next cycle.
REQ-022 out_data for any channel whose out_valid bit is 0 SHALL read all zeros.
REQ-023 Slots SHALL be independent: a stalled channel SHALL NOT block transfers addressed to other channels.
REQ-024 An out-of-range select (in_sel >= NCH, possible only when NCH is not a power of 2) SHALL be accepted and dropped, SHALL pulse err high in the next cycle, and SHALL increment drop_cnt, which saturates at 255.
REQ-025 in_data and in_sel SHALL be ignored while in_valid=0.
REQ-026 Holding register contents SHALL change only on a load; there SHALL be no spurious updates while a slot is stalled.

Reset
REQ-027 While rst=1 all out_valid bits SHALL be 0, out_data SHALL be 0, err SHALL be 0 and drop_cnt SHALL be 0 on the next edge.
REQ-028 A rst asserted while a slot is full SHALL discard the word; no output transfer SHALL be reported in that cycle.
REQ-029 in_ready SHALL be 0 while rst=1.

Configuration
REQ-030 Macro STREAM_DEMUX_BROADCAST_EN SHALL control broadcast support.
REQ-031 With the macro defined, an input in_bcast (1 bit) SHALL exist.
REQ-032 When in_bcast=1, in_ready SHALL be 1 only if every slot is empty or draining, and an input transfer SHALL load in_data into all NCH slots, ignoring in_sel and raising no err.
REQ-033 Without the macro, port in_bcast SHALL be absent and all routing SHALL be unicast only.

Verification
REQ-034 WIDTH=8, NCH=8, out_ready=all 1: send 0xA5 with sel=3 -> out_valid=8'h08 and slot 3=0xA5 one cycle later; all other slot data=0.
REQ-035 out_ready[2]=0: send 0x11 then 0x22 to sel=2 -> the second word stalls (in_ready=0); 0x33 to sel=5 is accepted meanwhile; raising out_ready[2] -> 0x11 is delivered, then 0x22, with no loss.
REQ-036 Slot 4 full with out_ready[4]=1 and a new word 0x7E to sel=4 in the same cycle -> out_valid[4] stays 1 and slot 4=0x7E next cycle.
REQ-037 NCH=6: send sel=7 three times -> in_ready=1 each time, err pulses three times, drop_cnt=3, no out_valid set; after 300 such words drop_cnt=255.
REQ-038 Slots 0, 1 and 6 full and stalled: assert rst for one cycle -> out_valid=0, out_data=0 and drop_cnt=0 on the next cycle.
REQ-039 With STREAM_DEMUX_BROADCAST_EN defined: in_bcast=1 and data 0x5A with all slots empty -> all 8 out_valid bits=1 and every slot=0x5A; if any slot is stalled full, in_ready=0.
